// File: rtl/alu_seq_core.sv
// alu_seq_core: registered execute-stage ALU with persistent {C,Z,N} flags, flush and flag restore.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 15; otherwise op 15 acts as NOP.
module alu_seq_core #(
    parameter int N       = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [N-1:0]       src,
    input  logic [N-1:0]       dst,
    input  logic [N-1:0]       imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    input  logic               flags_wr,
    input  logic [2:0]         flags_in,
    output logic               out_valid,
    output logic [N-1:0]       out,
    output logic [N-1:0]       out_hi,
    output logic [2:0]         flags_out,
    output logic               busy
);
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_LDI  = 4'd14;

    logic [N-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic         out_valid_q, out_valid_d;
    logic [2:0]   flags_q, flags_d;

    logic         accept, mul_start;
    logic [N-1:0] alu_res;
    logic         alu_c, alu_zn;
    logic [2:0]   alu_flags;
    logic [N:0]   sum_w, shl_w, shr_w;

    assign in_ready = !busy && !flush;
    assign accept   = in_valid && in_ready;

    // The extra bit on each shifter catches the last bit shifted out, including shamt==N.
    always_comb begin
        alu_res = out_q;
        alu_c   = flags_q[2];
        alu_zn  = 1'b0;
        sum_w   = '0;
        shl_w   = {1'b0, src} << shamt;
        shr_w   = {src, 1'b0} >> shamt;
        case (op)
            OP_NOT:  begin alu_res = ~src; alu_c = 1'b0; alu_zn = 1'b1; end
            OP_INC:  begin
                sum_w   = {1'b0, src} + {{N{1'b0}}, 1'b1};
                alu_res = sum_w[N-1:0]; alu_c = sum_w[N]; alu_zn = 1'b1;
            end
            OP_DEC:  begin alu_res = src - {{(N-1){1'b0}}, 1'b1}; alu_c = (src == '0); alu_zn = 1'b1; end
            OP_MOV:  alu_res = dst;
            OP_ADD:  begin
                sum_w   = {1'b0, src} + {1'b0, dst};
                alu_res = sum_w[N-1:0]; alu_c = sum_w[N]; alu_zn = 1'b1;
            end
            OP_SUB:  begin alu_res = src - dst; alu_c = (src < dst); alu_zn = 1'b1; end
            OP_AND:  begin alu_res = src & dst; alu_zn = 1'b1; end
            OP_OR:   begin alu_res = src | dst; alu_zn = 1'b1; end
            OP_SHL:  begin
                alu_res = shl_w[N-1:0]; alu_zn = 1'b1;
                if (shamt != '0) alu_c = shl_w[N];
            end
            OP_SHR:  begin
                alu_res = shr_w[N:1]; alu_zn = 1'b1;
                if (shamt != '0) alu_c = shr_w[0];
            end
            OP_SETC: alu_c = 1'b1;
            OP_CLRC: alu_c = 1'b0;
            OP_PASS: alu_res = src;
            OP_LDI:  alu_res = imm;
            default: ;
        endcase
        alu_flags = alu_zn ? {alu_c, (alu_res == '0), alu_res[N-1]} : {alu_c, flags_q[1:0]};
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(N);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d, prod_step;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N:0]       hi_sum;

    assign busy      = busy_q;
    assign mul_start = accept && (op == 4'd15);

    // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
    assign hi_sum    = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {hi_sum, prod_q[N-1:1]};
`else
    assign busy      = 1'b0;
    assign mul_start = 1'b0;
`endif

    always_comb begin
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        out_valid_d = 1'b0;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (busy_q) begin
            if (flush) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N-1)) begin
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    out_d       = prod_step[N-1:0];
                    out_hi_d    = prod_step[2*N-1:N];
                    out_valid_d = 1'b1;
                    flags_d     = {(prod_step[2*N-1:N] != '0), (prod_step == '0), prod_step[2*N-1]};
                end
            end
        end else if (mul_start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            prod_d  = {{N{1'b0}}, src};
            mcand_d = dst;
        end
`endif
        if (accept && !mul_start) begin
            out_d       = alu_res;
            out_hi_d    = '0;
            out_valid_d = 1'b1;
            flags_d     = alu_flags;
        end
        if (flags_wr) flags_d = flags_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_hi_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= 3'b000;
`ifdef ALU_MUL_EN
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
`ifdef ALU_MUL_EN
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign out_valid = out_valid_q;
    assign flags_out = flags_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: random traffic against an arithmetic reference model plus directed cases.
// Follows ALU_MUL_EN so the model matches whichever build of the DUT is compiled.
module tb_alu_seq_core;
    localparam int N = 16;
    localparam int SHAMT_W = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [3:0]         op = '0;
    logic [N-1:0]       src = '0, dst = '0, imm = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               flush = 1'b0;
    logic               flags_wr = 1'b0;
    logic [2:0]         flags_in = '0;
    logic               out_valid;
    logic [N-1:0]       out, out_hi;
    logic [2:0]         flags_out;
    logic               busy;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq_core #(.N(N), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src(src), .dst(dst), .imm(imm), .shamt(shamt),
        .flush(flush), .flags_wr(flags_wr), .flags_in(flags_in),
        .out_valid(out_valid), .out(out), .out_hi(out_hi),
        .flags_out(flags_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // Reference ALU: returns {result[15:0], C, Z, N} from plain integer arithmetic.
    function automatic logic [18:0] ref_alu(input int opc, input int a, input int b, input int im,
                                            input int s, input logic [15:0] prev, input logic [2:0] f);
        int r;
        int c;
        bit zn;
        logic [2:0] nf;
        r  = int'(prev);
        c  = f[2] ? 1 : 0;
        zn = 1'b1;
        case (opc)
            1:  begin r = (~a) & 32'hFFFF; c = 0; end
            2:  begin r = a + 1; c = r >> 16; r = r & 32'hFFFF; end
            3:  begin c = (a == 0) ? 1 : 0; r = (a - 1) & 32'hFFFF; end
            4:  begin r = b; zn = 1'b0; end
            5:  begin r = a + b; c = r >> 16; r = r & 32'hFFFF; end
            6:  begin c = (a < b) ? 1 : 0; r = (a - b) & 32'hFFFF; end
            7:  r = a & b;
            8:  r = a | b;
            9:  begin
                if (s == 0) r = a;
                else if (s < 16) begin c = (a >> (16 - s)) & 1; r = (a << s) & 32'hFFFF; end
                else if (s == 16) begin c = a & 1; r = 0; end
                else begin c = 0; r = 0; end
            end
            10: begin
                if (s == 0) r = a;
                else if (s < 16) begin c = (a >> (s - 1)) & 1; r = a >> s; end
                else if (s == 16) begin c = (a >> 15) & 1; r = 0; end
                else begin c = 0; r = 0; end
            end
            11: begin c = 1; zn = 1'b0; end
            12: begin c = 0; zn = 1'b0; end
            13: begin r = a; zn = 1'b0; end
            14: begin r = im; zn = 1'b0; end
            default: zn = 1'b0;
        endcase
        nf = zn ? {c[0], (r == 0), r[15]} : {c[0], f[1], f[0]};
        return {r[15:0], nf};
    endfunction

    logic [15:0] m_out, m_hi;
    logic        m_valid, m_busy;
    int          m_left;
    logic [31:0] m_prod;
    logic [2:0]  m_flags, m_nf;
    logic [18:0] m_rr;

    // Reference model: the multiply is just a countdown to a precomputed product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0; m_hi = '0; m_valid = 1'b0; m_busy = 1'b0;
            m_left = 0; m_prod = '0; m_flags = '0;
        end else begin
            m_nf    = m_flags;
            m_valid = 1'b0;
            if (m_busy) begin
                if (flush) m_busy = 1'b0;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy  = 1'b0;
                        m_valid = 1'b1;
                        m_out   = m_prod[15:0];
                        m_hi    = m_prod[31:16];
                        m_nf    = {(m_prod[31:16] != 0), (m_prod == 0), m_prod[31]};
                    end
                end
            end else if (in_valid && !flush) begin
                if (op == 4'd15 && MUL_EN) begin
                    m_busy = 1'b1;
                    m_left = N;
                    m_prod = {16'b0, src} * {16'b0, dst};
                end else begin
                    m_rr    = ref_alu(int'(op), int'(src), int'(dst), int'(imm), int'(shamt), m_out, m_flags);
                    m_out   = m_rr[18:3];
                    m_nf    = m_rr[2:0];
                    m_hi    = '0;
                    m_valid = 1'b1;
                end
            end
            if (flags_wr) m_nf = flags_in;
            m_flags = m_nf;
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out", 32'(out), 32'(m_out));
        chk("out_hi", 32'(out_hi), 32'(m_hi));
        chk("flags_out", 32'(flags_out), 32'(m_flags));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("in_ready", 32'(in_ready), 32'(!m_busy && !flush));
    end

    // Drive one cycle starting just after a rising edge; return just after the next one.
    task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] im, input logic [3:0] s, input logic v,
                         input logic fl, input logic fw, input logic [2:0] fin);
        op = o; src = a; dst = b; imm = im; shamt = s;
        in_valid = v; flush = fl; flags_wr = fw; flags_in = fin;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; flags_wr = 1'b0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
        drive(o, a, b, 16'h0, s, 1'b1, 1'b0, 1'b0, 3'b000);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic random_traffic(input int cycles, input bool_resets);
        for (int i = 0; i < cycles; i++) begin
            op       = 4'($urandom_range(0, 15));
            src      = pick16();
            dst      = pick16();
            imm      = 16'($urandom);
            shamt    = 4'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            flags_wr = ($urandom_range(0, 15) == 0);
            flags_in = 3'($urandom);
            if (bool_resets != 0 && $urandom_range(0, 199) == 0) rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        in_valid = 1'b0; flush = 1'b0; flags_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", 32'(out), 32'h0);
        chk("reset flags", 32'(flags_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Traffic, then a reset asserted mid-traffic must clear outputs at once.
        random_traffic(300, 0);
        in_valid = 1'b1; op = 4'd5; src = 16'h1111; dst = 16'h2222;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async rst out", 32'(out), 32'h0);
        chk("async rst out_valid", 32'(out_valid), 32'h0);
        chk("async rst flags", 32'(flags_out), 32'h0);
        chk("async rst busy", 32'(busy), 32'h0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(4'd5, 16'h0003, 16'h0004, 4'd0);
        chk("add 3+4 out", 32'(out), 32'h0007);
        chk("add 3+4 flags", 32'(flags_out), 32'b000);
        chk("add 3+4 valid", 32'(out_valid), 32'h1);
        issue(4'd5, 16'hFFFF, 16'h0001, 4'd0);
        chk("add carry out", 32'(out), 32'h0000);
        chk("add carry flags", 32'(flags_out), 32'b110);
        issue(4'd6, 16'h0002, 16'h0005, 4'd0);
        chk("sub borrow out", 32'(out), 32'hFFFD);
        chk("sub borrow flags", 32'(flags_out), 32'b101);
        issue(4'd4, 16'h0000, 16'h1234, 4'd0);
        chk("mov out", 32'(out), 32'h1234);
        chk("mov flags held", 32'(flags_out), 32'b101);
        issue(4'd9, 16'h8001, 16'h0, 4'd1);
        chk("shl1 out", 32'(out), 32'h0002);
        chk("shl1 flags", 32'(flags_out), 32'b100);
        issue(4'd10, 16'h0003, 16'h0, 4'd1);
        chk("shr1 out", 32'(out), 32'h0001);
        chk("shr1 flags", 32'(flags_out), 32'b100);
        issue(4'd9, 16'h0100, 16'h0, 4'd0);
        chk("shl0 out", 32'(out), 32'h0100);
        chk("shl0 C held", 32'(flags_out), 32'b100);
        issue(4'd9, 16'h0001, 16'h0, 4'd15);
        chk("shl15 out", 32'(out), 32'h8000);
        chk("shl15 flags", 32'(flags_out), 32'b001);
        drive(4'd11, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b1, 3'b010);
        chk("setc+flags_wr flags", 32'(flags_out), 32'b010);
        chk("setc out held", 32'(out), 32'h8000);
        issue(4'd0, 16'h5555, 16'h0, 4'd0);
        chk("nop valid", 32'(out_valid), 32'h1);
        chk("nop out held", 32'(out), 32'h8000);
        drive(4'd5, 16'h1, 16'h1, 16'h0, 4'd0, 1'b1, 1'b1, 1'b1, 3'b101);
        chk("flush no accept", 32'(out_valid), 32'h0);
        chk("flush+flags_wr", 32'(flags_out), 32'b101);
        issue(4'd14, 16'h0, 16'h0, 4'd0);
        chk("ldi zero out", 32'(out), 32'h0);
        chk("ldi flags held", 32'(flags_out), 32'b101);

`ifdef ALU_MUL_EN
        issue(4'd15, 16'h1234, 16'h0100, 4'd0);
        chk("mul busy", 32'(busy), 32'h1);
        in_valid = 1'b1; op = 4'd5; src = 16'h0001; dst = 16'h0001;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin cyc = k; break; end
        end
        chk("mul latency", 32'(cyc), 32'd16);
        chk("mul out", 32'(out), 32'h3400);
        chk("mul out_hi", 32'(out_hi), 32'h0012);
        chk("mul flags", 32'(flags_out), 32'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("add after mul", 32'(out), 32'h0002);
        chk("add after mul hi", 32'(out_hi), 32'h0);

        issue(4'd15, 16'h0003, 16'h0005, 4'd0);
        repeat (3) begin @(posedge clk); #1; end
        drive(4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1, 1'b0, 3'b000);
        chk("mul flush busy", 32'(busy), 32'h0);
        chk("mul flush valid", 32'(out_valid), 32'h0);
        chk("mul flush flags", 32'(flags_out), 32'b000);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        chk("no result after flush", 32'(cyc), 32'h0);
`else
        issue(4'd15, 16'h1234, 16'h0100, 4'd0);
        chk("op15 nop valid", 32'(out_valid), 32'h1);
        chk("op15 nop out", 32'(out), 32'h0);
        chk("op15 nop busy", 32'(busy), 32'h0);
`endif
        issue(4'd5, 16'h0003, 16'h0004, 4'd0);
        chk("add after flush", 32'(out), 32'h0007);

        random_traffic(3000, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Takes one operation per accepted handshake and returns a registered result with a persistent condition-code register (C/Z/N).
- Adds an iterative multi-cycle multiplier, a pipeline flush, and a flag-restore port for interrupt return.
- Sits in the execute stage, between decode/operand forwarding and the memory stage.

Parameters:
N, 16, datapath width in bits (N >= 4)
SHAMT_W, 4, width of the shift-amount field; shift amounts >= N produce a zero result

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept; equals !busy && !flush
op  in  4  opcode (see Behaviour)
src  in  N  source operand
dst  in  N  destination operand
imm  in  N  immediate for LDI
shamt  in  SHAMT_W  shift amount
flush  in  1  kill in-flight/pending operation
flags_wr  in  1  load flag register from flags_in
flags_in  in  3  {C,Z,N} restore value
out_valid  out  1  result valid, one-cycle pulse per operation
out  out  N  result (product low half for MUL)
out_hi  out  N  product high half for MUL, else 0
flags_out  out  3  {C,Z,N} registered flags
busy  out  1  multiplier iterating

Behaviour:
- Reset (async, rst_n=0): out=0, out_hi=0, out_valid=0, flags_out=3'b000, busy=0, multiplier state cleared. Reset asserted mid-MUL aborts it with no output.
- Accept: in_valid && in_ready on a rising edge.
- Single-cycle ops: out/out_valid/flags registered on the accept edge, so latency is 1 cycle. Back-to-back issue is allowed every cycle.
- Opcodes, with flags affected:
  - 0 NOP: out_valid=1, out unchanged, no flag change.
  - 1 NOT: ~src; C=0; Z,N.
  - 2 INC: src+1; C=carry out of bit N-1; Z,N.
  - 3 DEC: src-1; C=1 iff src==0; Z,N.
  - 4 MOV: dst; no flag change.
  - 5 ADD: src+dst; C=carry out; Z,N.
  - 6 SUB: src-dst; C=1 iff src<dst unsigned (borrow); Z,N.
  - 7 AND, 8 OR: C unchanged; Z,N.
  - 9 SHL: src<<shamt; C=last bit shifted out; Z,N.
  - 10 SHR: logical src>>shamt; C=last bit shifted out; Z,N.
  - 11 SETC: C=1 only. 12 CLRC: C=0 only. Neither changes out.
  - 13 PASS: src; no flag change.
  - 14 LDI: imm; no flag change.
  - 15 MUL: see Optional Feature.
- Z=(result==0), N=result[N-1], computed on the N-bit result.
- Shift boundaries:
  - shamt==0: result=src, C unchanged.
  - shamt>=N: result=0; C=src[0] for SHL if shamt==N, else 0 (same rule for SHR with src[N-1]).
- out_hi=0 for every non-MUL op.
- flags_wr has priority over any same-cycle ALU flag update: flags_out takes flags_in on that edge. The ALU result is still produced.
- flush: in_ready=0 that cycle and nothing is accepted. On the next edge out_valid=0 and an in-flight MUL is aborted (busy=0, no result). Flags are unchanged by flush.
- Flush and flags_wr in the same cycle: flags_wr still applies.

Optional Feature:
Macro ALU_MUL_EN.
- Defined:
  - op 15 is an unsigned N x N shift-add multiply, one partial-product step per cycle.
  - busy=1 from the cycle after accept until the result edge. Result on the N-th edge after accept, so latency = N cycles.
  - out=product[N-1:0], out_hi=product[2N-1:N], out_valid pulses once.
  - C=(out_hi!=0); Z=(2N-bit product==0); N=product[2N-1].
  - in_ready=0 while busy.
- Undefined: op 15 behaves as NOP. busy is tied 0. No multiplier logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 mid-traffic -> out=0, out_valid=0, flags_out=000, busy=0 immediately; after release the first ADD 0x0003+0x0004 -> out=0x0007, flags 000 one cycle later.
- Carry/borrow: ADD 0xFFFF+0x0001 -> out=0x0000, flags {1,1,0}. SUB 0x0002-0x0005 -> out=0xFFFD, flags {1,0,1}. Then MOV -> flags unchanged.
- Shifts: SHL 0x8001 shamt=1 -> 0x0002, C=1. SHR 0x0003 shamt=1 -> 0x0001, C=1. SHL shamt=0 -> src, C held. SHL shamt=15 on 0x0001 -> 0x8000, N=1.
- Flag priority: SETC with flags_wr=1, flags_in=3'b010 in the same cycle -> flags_out=010.
- MUL (ALU_MUL_EN): 0x1234 x 0x0100 -> out=0x3400, out_hi=0x0012, C=1, after exactly 16 cycles. in_valid held high meanwhile is not accepted until busy falls.
- Flush mid-MUL at cycle 5 -> busy=0 next edge, no out_valid, flags unchanged; a following ADD is accepted normally.
